// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
package ram_arbiter_pkg;

   localparam int REG_BUS_W  = 32;
   typedef logic [REG_BUS_W-1:0] reg_bus_t;

   localparam int BYTE_LANES = 4;

   localparam int ARB_IDX_W  = 1;
   typedef logic [ARB_IDX_W-1:0] arb_idx_t;

   localparam arb_idx_t ARB_M0 = 1'b0;
   localparam arb_idx_t ARB_M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// Two-input one-hot grant generator. ARB_ROUND_ROBIN_EN selects alternating
// priority; without it master 0 always wins and no priority state exists.
module arb_rr2
   import ram_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       clk,
   input  logic       rstn,
`endif
   input  logic [1:0] req,
   output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
   arb_idx_t prio;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || prio == ARB_M0))
         gnt = 2'b01;
      else if (req[1])
         gnt = 2'b10;
   end

   // Point at whichever master lost (or was idle) on every grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         prio <= ARB_M0;
      else if (gnt[0])
         prio <= ARB_M1;
      else if (gnt[1])
         prio <= ARB_M0;
   end
`else
   always_comb begin
      gnt = 2'b00;
      if (req[0])
         gnt = 2'b01;
      else if (req[1])
         gnt = 2'b10;
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-port data RAM, with one-cycle
// read-return routing. ARB_ROUND_ROBIN_EN enables alternating priority.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DW = REG_BUS_W,
   parameter int AW = 32
) (
   input  logic                  clk,
   input  logic                  rstn,

   input  logic                  m0_req,
   input  logic [BYTE_LANES-1:0] m0_wen,
   input  logic [AW-1:0]         m0_addr,
   input  logic [DW-1:0]         m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DW-1:0]         m0_rdata,

   input  logic                  m1_req,
   input  logic [BYTE_LANES-1:0] m1_wen,
   input  logic [AW-1:0]         m1_addr,
   input  logic [DW-1:0]         m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DW-1:0]         m1_rdata,

   output logic [BYTE_LANES-1:0] ram_wen,
   output logic                  ram_ren,
   output logic [AW-1:0]         ram_addr,
   output logic [DW-1:0]         ram_wdata,
   input  logic [DW-1:0]         ram_rdata
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       rd_pend;
   arb_idx_t   rd_src;

   // Requests are masked while in reset so no grant leaks out combinationally.
   assign req = {m1_req, m0_req} & {2{rstn}};

   arb_rr2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
      .clk  (clk),
      .rstn (rstn),
`endif
      .req  (req),
      .gnt  (gnt)
   );

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   always_comb begin
      ram_wen   = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (gnt[0]) begin
         ram_wen   = m0_wen;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (gnt[1]) begin
         ram_wen   = m1_wen;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

   assign ram_ren = (|gnt) && (ram_wen == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_pend <= 1'b0;
         rd_src  <= ARB_M0;
      end else begin
         rd_pend <= ram_ren;
         rd_src  <= gnt[1] ? ARB_M1 : ARB_M0;
      end
   end

   assign m0_rvalid = rd_pend && (rd_src == ARB_M0);
   assign m1_rvalid = rd_pend && (rd_src == ARB_M1);
   assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
   assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM stand-in, cycle-level reference model, and
// directed vectors with literal expectations. Honours ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req, m1_req;
   logic [3:0]  m0_wen, m1_wen;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [3:0]  ram_wen;
   logic        ram_ren;
   logic [31:0] ram_addr, ram_wdata;
   logic [31:0] ram_rdata = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   ram_arbiter #(.DW(32), .AW(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .m0_req    (m0_req),
      .m0_wen    (m0_wen),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_wen    (m1_wen),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .ram_wen   (ram_wen),
      .ram_ren   (ram_ren),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM stand-in driven by the DUT's RAM port
   logic [31:0] ram_mem [0:63];
   logic [31:0] ref_mem [0:63];

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram_mem[i] = 32'h0101_0101 * i;
         ref_mem[i] = 32'h0101_0101 * i;
      end
      ram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;   // 0x10
      ram_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;   // 0x20
   end

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_wen[b]) ram_mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_ren) ram_rdata <= ram_mem[ram_addr[7:2]];
   end

   // Reference model: transaction-level view of who wins and what returns
   bit          mdl_prefer_m1;
   bit          mdl_pend;
   bit          mdl_src;
   logic [31:0] mdl_data;
   bit          any, win;
   logic [3:0]  s_wen;
   logic [31:0] s_addr, s_wdata;

   always @(negedge clk) begin
      if (!rstn) begin
         mdl_prefer_m1 = 1'b0;
         mdl_pend      = 1'b0;
         mdl_src       = 1'b0;
         chk("mdl_rst_gnt",    {30'b0, m1_gnt, m0_gnt}, 32'h0);
         chk("mdl_rst_ramctl", {27'b0, ram_ren, ram_wen}, 32'h0);
         chk("mdl_rst_addr",   ram_addr, 32'h0);
         chk("mdl_rst_wdata",  ram_wdata, 32'h0);
         chk("mdl_rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
         chk("mdl_rst_rdata0", m0_rdata, 32'h0);
         chk("mdl_rst_rdata1", m1_rdata, 32'h0);
      end else begin
         any = m0_req || m1_req;
         if (m0_req && m1_req) win = RR ? mdl_prefer_m1 : 1'b0;
         else                  win = !m0_req;
         s_wen   = !any ? 4'h0  : (win ? m1_wen   : m0_wen);
         s_addr  = !any ? 32'h0 : (win ? m1_addr  : m0_addr);
         s_wdata = !any ? 32'h0 : (win ? m1_wdata : m0_wdata);
         chk("mdl_gnt0",   {31'b0, m0_gnt}, {31'b0, any && !win});
         chk("mdl_gnt1",   {31'b0, m1_gnt}, {31'b0, any && win});
         chk("mdl_ram_wen", {28'b0, ram_wen}, {28'b0, s_wen});
         chk("mdl_ram_ren", {31'b0, ram_ren}, {31'b0, any && s_wen == 4'h0});
         chk("mdl_ram_addr",  ram_addr, s_addr);
         chk("mdl_ram_wdata", ram_wdata, s_wdata);
         chk("mdl_rvalid0", {31'b0, m0_rvalid}, {31'b0, mdl_pend && !mdl_src});
         chk("mdl_rvalid1", {31'b0, m1_rvalid}, {31'b0, mdl_pend && mdl_src});
         chk("mdl_rdata0", m0_rdata, (mdl_pend && !mdl_src) ? mdl_data : 32'h0);
         chk("mdl_rdata1", m1_rdata, (mdl_pend && mdl_src) ? mdl_data : 32'h0);
         mdl_pend = any && s_wen == 4'h0;
         mdl_src  = win;
         mdl_data = ref_mem[s_addr[7:2]];
         if (any)
            for (int b = 0; b < 4; b++)
               if (s_wen[b]) ref_mem[s_addr[7:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
         if (any) mdl_prefer_m1 = !win;
      end
   end

   task automatic set_m0(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      m0_req = r; m0_wen = w; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set_m1(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      m1_req = r; m1_wen = w; m1_addr = a; m1_wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   bit exp_g0 [4];

   initial begin
      rstn = 1'b0;
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0);
      step(); step();
      #1;
      chk("reset_gnt",     {30'b0, m1_gnt, m0_gnt}, 32'h0);
      chk("reset_ram_ren", {31'b0, ram_ren}, 32'h0);
      chk("reset_rvalid",  {30'b0, m1_rvalid, m0_rvalid}, 32'h0);

      rstn = 1'b1;
      #1;
      chk("cold_conflict_gnt0", {31'b0, m0_gnt}, 32'h1);
      chk("cold_conflict_gnt1", {31'b0, m1_gnt}, 32'h0);
      chk("m0_read_ren",  {31'b0, ram_ren}, 32'h1);
      chk("m0_read_addr", ram_addr, 32'h10);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("m0_read_rvalid", {31'b0, m0_rvalid}, 32'h1);
      chk("m0_read_rdata",  m0_rdata, 32'hDEADBEEF);
      chk("m0_read_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
      chk("m1_alone_gnt", {31'b0, m1_gnt}, 32'h1);
      step();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("m1_read_rdata", m1_rdata, 32'h11223344);

      // Sustained conflict
      exp_g0 = RR ? '{1'b1, 1'b0, 1'b1, 1'b0} : '{1'b1, 1'b1, 1'b1, 1'b1};
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("conflict_gnt0", {31'b0, m0_gnt}, {31'b0, exp_g0[i]});
         chk("conflict_gnt1", {31'b0, m1_gnt}, {31'b0, !exp_g0[i]});
         step();
      end
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      step();

      // Master 1 byte write, then read-back through master 0
      set_m1(1'b1, 4'b0100, 32'h20, 32'h00AA0000);
      #1;
      chk("bytewr_ram_wen",   {28'b0, ram_wen}, 32'h4);
      chk("bytewr_ram_addr",  ram_addr, 32'h20);
      chk("bytewr_ram_wdata", ram_wdata, 32'h00AA0000);
      chk("bytewr_ram_ren",   {31'b0, ram_ren}, 32'h0);
      step();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("bytewr_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
      set_m0(1'b1, 4'h0, 32'h20, 32'h0);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("bytewr_readback", m0_rdata, 32'h11AA3344);
      step();

      // Back-to-back reads from different masters
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0);
      #1;
      chk("b2b_m0_rdata",  m0_rdata, 32'hDEADBEEF);
      chk("b2b_m1_rvalid_early", {31'b0, m1_rvalid}, 32'h0);
      step();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("b2b_m1_rdata",  m1_rdata, 32'h11AA3344);
      chk("b2b_m0_rvalid_late", {31'b0, m0_rvalid}, 32'h0);

      // m1 read followed by m0 full-word write
      set_m1(1'b1, 4'h0, 32'h10, 32'h0);
      step();
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      set_m0(1'b1, 4'hF, 32'h30, 32'hFFFF0000);
      #1;
      chk("mix_m1_rdata", m1_rdata, 32'hDEADBEEF);
      chk("mix_m0_gnt",   {31'b0, m0_gnt}, 32'h1);
      chk("mix_ram_wen",  {28'b0, ram_wen}, 32'hF);
      step();
      set_m0(1'b1, 4'h0, 32'h30, 32'h0);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("mix_readback", m0_rdata, 32'hFFFF0000);

      // Reset in the cycle after a granted read
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      rstn = 1'b0;
      #1;
      chk("rstmid_rvalid0", {31'b0, m0_rvalid}, 32'h0);
      chk("rstmid_rvalid1", {31'b0, m1_rvalid}, 32'h0);
      step(); step();
      set_m0(1'b1, 4'h0, 32'h10, 32'h0);
      set_m1(1'b1, 4'h0, 32'h20, 32'h0);
      rstn = 1'b1;
      #1;
      chk("rstmid_prio_gnt0", {31'b0, m0_gnt}, 32'h1);
      chk("rstmid_prio_gnt1", {31'b0, m1_gnt}, 32'h0);
      step();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);
      set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
